// File: rtl/scmp_seq_alu.sv
// -----------------------------------------------------------------------------
// scmp_seq_alu
//   Registered, parametrised SC/MP-style ALU with a start/done handshake.
//   Single-cycle ops (AND/OR/XOR/ADD/RRL/INC/DEC/NUL/DAD/pass A) finish one
//   clock after the accepted start. MUL/DIV iterate one bit per clock and
//   finish WIDTH+1 clocks after the accepted start.
//
//   Build option: define SCMP_SEQ_ALU_MULDIV_EN to include the iterative
//   multiply/divide datapath. Without it, opcodes 9/10 behave as pass A.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start_i  in   launch op (ignored while busy_o=1)
//   op_i     in   opcode [3:0]
//   a_i      in   operand A (multiplicand / dividend)
//   b_i      in   operand B (multiplier / divisor)
//   cy_i     in   carry/link in
//   ov_i     in   overflow in
//   busy_o   out  iterative op in progress
//   done_o   out  one-cycle pulse, results valid
//   res_o    out  result (MUL low half, DIV quotient)
//   ext_o    out  MUL high half, DIV remainder, 0 otherwise
//   cy_o     out  carry out
//   hcy_o    out  half carry (carry out of bit 3 / BCD digit 0)
//   ov_o     out  overflow out
// -----------------------------------------------------------------------------
module scmp_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cy_i,
    input  logic             ov_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] ext_o,
    output logic             cy_o,
    output logic             hcy_o,
    output logic             ov_o
);

    localparam int NIB = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] res_reg, ext_reg;
    logic             cy_reg, hcy_reg, ov_reg;
    logic             start_accept;
    logic             launch_run;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   add_sum;
    logic [4:0]       add_lo;
    logic [WIDTH-1:0] dad_res;
    logic             dad_cy, dad_hcy;
    logic [WIDTH-1:0] sc_res;
    logic             sc_cy, sc_hcy, sc_ov;

    assign add_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cy_i};
    assign add_lo  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, cy_i};

    // Decimal add: each digit sum above 9 is corrected by +6 and carries on.
    // Non-BCD digits simply follow the same rule.
    always_comb begin
        logic [4:0] nib;
        logic       c;
        dad_res = '0;
        dad_hcy = 1'b0;
        c       = cy_i;
        for (int i = 0; i < NIB; i++) begin
            nib = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, c};
            c   = (nib > 5'd9);
            dad_res[4*i +: 4] = c ? (nib[3:0] + 4'd6) : nib[3:0];
            if (i == 0) dad_hcy = c;
        end
        dad_cy = c;
    end

    always_comb begin
        sc_res = a_i;
        sc_cy  = cy_i;
        sc_hcy = 1'b0;
        sc_ov  = ov_i;
        case (op_i)
            4'd0: sc_res = a_i & b_i;
            4'd1: sc_res = a_i | b_i;
            4'd2: sc_res = a_i ^ b_i;
            4'd3: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_cy  = add_sum[WIDTH];
                sc_hcy = add_lo[4];
                sc_ov  = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            4'd4: begin
                sc_res = {cy_i, a_i[WIDTH-1:1]};
                sc_cy  = a_i[0];
            end
            4'd5: begin
                sc_res = a_i + 1'b1;
                sc_cy  = &a_i;
            end
            4'd6: begin
                sc_res = a_i - 1'b1;
                sc_cy  = ~|a_i;
            end
            4'd7: sc_res = b_i;
            4'd8: begin
                sc_res = dad_res;
                sc_cy  = dad_cy;
                sc_hcy = dad_hcy;
            end
            default: sc_res = a_i;
        endcase
    end

    // ---------------- iterative multiply / divide ----------------
`ifdef SCMP_SEQ_ALU_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] opb_reg;      // multiplicand (MUL) or divisor (DIV)
    logic             is_div_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] step_res, step_ext;

    assign launch_run = (op_i == 4'd9) || (op_i == 4'd10);

    // MUL: {ext,res} is the product register; res starts as the multiplier and
    // its LSB selects whether the multiplicand is added before shifting right.
    // DIV: {ext,res} shifts left; ext holds the partial remainder and the
    // quotient bits enter at the bottom of res. A zero divisor never borrows,
    // which naturally yields quotient all-ones and remainder A.
    always_comb begin
        mul_sum   = {1'b0, ext_reg} + (res_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {ext_reg, res_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_reg};
        if (is_div_reg) begin
            if (div_diff[WIDTH+1]) begin
                step_ext = div_shift[WIDTH-1:0];
                step_res = {res_reg[WIDTH-2:0], 1'b0};
            end else begin
                step_ext = div_diff[WIDTH-1:0];
                step_res = {res_reg[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_ext = mul_sum[WIDTH:1];
            step_res = {mul_sum[0], res_reg[WIDTH-1:1]};
        end
    end
`else
    assign launch_run = 1'b0;
`endif

    // ---------------- control ----------------
    assign start_accept = start_i && (state_reg != RUN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_i) state_next = launch_run ? RUN : FIN;
            FIN:  state_next = start_i ? (launch_run ? RUN : FIN) : IDLE;
`ifdef SCMP_SEQ_ALU_MULDIV_EN
            RUN:  if (cnt_reg == CNT_W'(1)) state_next = FIN;
`else
            RUN:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            res_reg    <= '0;
            ext_reg    <= '0;
            cy_reg     <= 1'b0;
            hcy_reg    <= 1'b0;
            ov_reg     <= 1'b0;
`ifdef SCMP_SEQ_ALU_MULDIV_EN
            cnt_reg    <= '0;
            opb_reg    <= '0;
            is_div_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
`ifdef SCMP_SEQ_ALU_MULDIV_EN
                if (launch_run) begin
                    res_reg    <= (op_i == 4'd10) ? a_i : b_i;
                    opb_reg    <= (op_i == 4'd10) ? b_i : a_i;
                    is_div_reg <= (op_i == 4'd10);
                    ext_reg    <= '0;
                    cy_reg     <= cy_i;
                    hcy_reg    <= 1'b0;
                    ov_reg     <= ov_i;
                    cnt_reg    <= CNT_W'(WIDTH);
                end else
`endif
                begin
                    res_reg <= sc_res;
                    ext_reg <= '0;
                    cy_reg  <= sc_cy;
                    hcy_reg <= sc_hcy;
                    ov_reg  <= sc_ov;
                end
            end
`ifdef SCMP_SEQ_ALU_MULDIV_EN
            else if (state_reg == RUN) begin
                res_reg <= step_res;
                ext_reg <= step_ext;
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    if (is_div_reg) begin
                        cy_reg <= ~|opb_reg;
                        ov_reg <= ~|opb_reg;
                    end else begin
                        cy_reg <= |step_ext;
                    end
                end
            end
`endif
        end
    end

    assign busy_o = (state_reg == RUN);
    assign done_o = (state_reg == FIN);
    assign res_o  = res_reg;
    assign ext_o  = ext_reg;
    assign cy_o   = cy_reg;
    assign hcy_o  = hcy_reg;
    assign ov_o   = ov_reg;

endmodule

// File: tb/tb_scmp_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_scmp_seq_alu
//   Self-checking bench: an 8-bit and a 16-bit ALU instance, directed cases
//   followed by randomized ops checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_scmp_seq_alu;

`ifdef SCMP_SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wide = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = '0, b = '0;
    logic        cy = 1'b0, ov = 1'b0;

    logic        d8_busy, d8_done, d8_cy, d8_hcy, d8_ov;
    logic [7:0]  d8_res, d8_ext;
    logic        d16_busy, d16_done, d16_cy, d16_hcy, d16_ov;
    logic [15:0] d16_res, d16_ext;

    logic        o_busy, o_done, o_cy, o_hcy, o_ov;
    logic [15:0] o_res, o_ext;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scmp_seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start & ~wide), .op_i(op),
        .a_i(a[7:0]), .b_i(b[7:0]), .cy_i(cy), .ov_i(ov),
        .busy_o(d8_busy), .done_o(d8_done), .res_o(d8_res), .ext_o(d8_ext),
        .cy_o(d8_cy), .hcy_o(d8_hcy), .ov_o(d8_ov)
    );

    scmp_seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start & wide), .op_i(op),
        .a_i(a), .b_i(b), .cy_i(cy), .ov_i(ov),
        .busy_o(d16_busy), .done_o(d16_done), .res_o(d16_res), .ext_o(d16_ext),
        .cy_o(d16_cy), .hcy_o(d16_hcy), .ov_o(d16_ov)
    );

    always_comb begin
        if (wide) begin
            o_busy = d16_busy; o_done = d16_done; o_res = d16_res; o_ext = d16_ext;
            o_cy = d16_cy; o_hcy = d16_hcy; o_ov = d16_ov;
        end else begin
            o_busy = d8_busy; o_done = d8_done; o_res = {8'h00, d8_res};
            o_ext = {8'h00, d8_ext}; o_cy = d8_cy; o_hcy = d8_hcy; o_ov = d8_ov;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model computed directly from the arithmetic definitions.
    function automatic void ref_model(input int w, input logic [3:0] o,
                                      input longint av, input longint bv,
                                      input bit ci, input bit vi,
                                      output longint r, output longint e,
                                      output bit co, output bit ho, output bit vo,
                                      output int lat);
        longint mask = (longint'(1) << w) - 1;
        longint s;
        bit c;
        r = av; e = 0; co = ci; ho = 0; vo = vi; lat = 1;
        case (o)
            4'd0: r = av & bv;
            4'd1: r = av | bv;
            4'd2: r = av ^ bv;
            4'd3: begin
                s  = av + bv + longint'(ci);
                r  = s & mask;
                co = ((s >> w) & 1) != 0;
                ho = (((av & 15) + (bv & 15) + longint'(ci)) >> 4) != 0;
                vo = (((av >> (w-1)) & 1) == ((bv >> (w-1)) & 1)) &&
                     (((r >> (w-1)) & 1) != ((av >> (w-1)) & 1));
            end
            4'd4: begin
                r  = (longint'(ci) << (w-1)) | (av >> 1);
                co = (av & 1) != 0;
            end
            4'd5: begin r = (av + 1) & mask; co = (av == mask); end
            4'd6: begin r = (av - 1) & mask; co = (av == 0); end
            4'd7: r = bv;
            4'd8: begin
                c = ci; r = 0;
                for (int d = 0; d < w/4; d++) begin
                    s = ((av >> (4*d)) & 15) + ((bv >> (4*d)) & 15) + longint'(c);
                    if (s > 9) begin s = s + 6; c = 1; end else c = 0;
                    r = r | ((s & 15) << (4*d));
                    if (d == 0) ho = c;
                end
                co = c;
            end
            4'd9: if (MD) begin
                s = av * bv; r = s & mask; e = s >> w; co = (e != 0); lat = w + 1;
            end
            4'd10: if (MD) begin
                lat = w + 1;
                if (bv == 0) begin r = mask; e = av; co = 1; vo = 1; end
                else begin r = av / bv; e = av % bv; co = 0; vo = 0; end
            end
            default: r = av;
        endcase
    endfunction

    longint obs_res, obs_ext;
    bit     obs_cy, obs_ov;

    // One transaction: start, scramble inputs, wait for done, compare.
    // With spam=1 start_i stays high (with an ADD) while the op is busy.
    task automatic run_op(input string tag, input bit w16, input logic [3:0] o,
                          input longint av, input longint bv, input bit ci,
                          input bit vi, input bit spam);
        int w = w16 ? 16 : 8;
        longint er, ee; bit ec, eh, ev; int el;
        int n, bc, lim;
        ref_model(w, o, av, bv, ci, vi, er, ee, ec, eh, ev, el);
        lim = 2 * w + 8;
        @(negedge clk);
        wide = w16; op = o; a = 16'(av); b = 16'(bv); cy = ci; ov = vi; start = 1'b1;
        @(posedge clk); #1;
        if (spam) begin
            op = 4'd3; a = 16'($urandom); b = 16'($urandom);
        end else begin
            start = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            cy = 1'($urandom); ov = 1'($urandom);
        end
        n = 1; bc = 0;
        while (!o_done && n < lim) begin
            if (o_busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        obs_res = longint'(o_res); obs_ext = longint'(o_ext);
        obs_cy = o_cy; obs_ov = o_ov;
        $display("op=%0d w=%0d a=0x%0h b=0x%0h ci=%0d -> res=0x%0h ext=0x%0h cy=%0d hcy=%0d ov=%0d lat=%0d [%s]",
                 o, w, av, bv, ci, o_res, o_ext, o_cy, o_hcy, o_ov, n, tag);
        check({tag, ".done"}, longint'(o_done), 1);
        check({tag, ".lat"},  longint'(n), longint'(el));
        check({tag, ".busy"}, longint'(bc), longint'(el - 1));
        check({tag, ".res"},  obs_res, er);
        check({tag, ".ext"},  obs_ext, ee);
        check({tag, ".cy"},   longint'(o_cy), longint'(ec));
        check({tag, ".hcy"},  longint'(o_hcy), longint'(eh));
        check({tag, ".ov"},   longint'(o_ov), longint'(ev));
        if (spam) begin
            @(posedge clk); #1;
            check({tag, ".no_extra_done"}, longint'(o_done), 0);
            check({tag, ".res_hold"}, longint'(o_res), er);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        longint ra, rb;
        logic [3:0] ro;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", longint'(d8_busy), 0);
        check("rst.done", longint'(d8_done), 0);
        check("rst.res",  longint'(d8_res), 0);
        check("rst.ext",  longint'(d8_ext), 0);
        check("rst.flags", longint'({d8_cy, d8_hcy, d8_ov}), 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        run_op("add", 1'b0, 4'd3, 'h7F, 'h01, 1'b0, 1'b0, 1'b0);
        check("add.res_const", obs_res, 'h80);
        check("add.ov_const", longint'(obs_ov), 1);
        run_op("dad", 1'b0, 4'd8, 'h59, 'h48, 1'b1, 1'b0, 1'b0);
        check("dad.res_const", obs_res, 'h08);
        run_op("inc_ff", 1'b0, 4'd5, 'hFF, 'h00, 1'b0, 1'b0, 1'b0);
        check("inc.cy_const", longint'(obs_cy), 1);
        run_op("dec_00", 1'b0, 4'd6, 'h00, 'h00, 1'b0, 1'b0, 1'b0);
        check("dec.res_const", obs_res, 'hFF);
        run_op("rrl", 1'b0, 4'd4, 'h81, 'h00, 1'b1, 1'b0, 1'b0);
        run_op("op9", 1'b0, 4'd9, 'h3C, 'h55, 1'b1, 1'b0, 1'b0);
        run_op("mul_ff", 1'b0, 4'd9, 'hFF, 'hFF, 1'b0, 1'b1, 1'b0);
`ifdef SCMP_SEQ_ALU_MULDIV_EN
        check("mul.res_const", obs_res, 'h01);
        check("mul.ext_const", obs_ext, 'hFE);
`else
        check("op9.pass_const", obs_res, 'hFF);
`endif
        run_op("mul_spam", 1'b0, 4'd9, 'hA7, 'h3B, 1'b0, 1'b0, MD);
        run_op("div16", 1'b1, 4'd10, 1000, 7, 1'b1, 1'b1, 1'b0);
        run_op("div16_z", 1'b1, 4'd10, 1000, 0, 1'b0, 1'b0, 1'b0);
`ifdef SCMP_SEQ_ALU_MULDIV_EN
        check("div16.z_res_const", obs_res, 'hFFFF);
        check("div16.z_ext_const", obs_ext, 1000);
`endif

        // Back-to-back single-cycle ops
        @(negedge clk);
        wide = 1'b0; op = 4'd2; a = 16'h005A; b = 16'h000F; cy = 1'b0; ov = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("b2b.xor_done", longint'(o_done), 1);
        check("b2b.xor_res", longint'(o_res), 'h55);
        op = 4'd5; a = 16'h00FF;
        @(posedge clk); #1;
        start = 1'b0;
        $display("b2b xor/inc -> done=%0d res=0x%0h cy=%0d", o_done, o_res, o_cy);
        check("b2b.inc_done", longint'(o_done), 1);
        check("b2b.inc_res", longint'(o_res), 'h00);
        check("b2b.inc_cy", longint'(o_cy), 1);
        @(posedge clk); #1;
        check("b2b.idle", longint'(o_done), 0);

        // Reset in the middle of a divide
        @(negedge clk);
        wide = 1'b0; op = 4'd10; a = 16'h00C8; b = 16'h0009; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        $display("mid-op reset -> busy=%0d done=%0d res=0x%0h ext=0x%0h", o_busy, o_done, o_res, o_ext);
        check("rstmid.busy", longint'(o_busy), 0);
        check("rstmid.done", longint'(o_done), 0);
        check("rstmid.res", longint'(o_res), 0);
        check("rstmid.ext", longint'(o_ext), 0);
        check("rstmid.flags", longint'({o_cy, o_hcy, o_ov}), 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_done || o_busy) seen++;
        end
        check("rstmid.no_done", longint'(seen), 0);
        run_op("add_after_rst", 1'b0, 4'd3, 'h12, 'h34, 1'b1, 1'b0, 1'b0);

        // Randomized ops, 8-bit
        for (int i = 0; i < 150; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = longint'($urandom_range(0, 255));
            rb = longint'($urandom_range(0, 255));
            if (ro == 4'd10 && $urandom_range(0, 5) == 0) rb = 0;
            run_op("rnd8", 1'b0, ro, ra, rb, 1'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Randomized ops, 16-bit
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = longint'($urandom_range(0, 65535));
            rb = longint'($urandom_range(0, 65535));
            if (ro == 4'd10 && $urandom_range(0, 5) == 0) rb = 0;
            run_op("rnd16", 1'b1, ro, ra, rb, 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
